uart_tx_arbiter: RTL

- Shares the single UART transmitter between two byte-stream requesters: requester 0 is the sample-dump path and requester 1 is the status/message path.
- Grants the UART for a whole frame, which ends at the byte flagged last, then re-arbitrates between frames.
- Drives the UART load/empty handshake, so requesters only use a valid/ready byte interface.
- Sits between the sample-stream controller, the status source and the UART TX core.

---
 rtl/uart_tx_arb_pkg.sv | 17 +
 rtl/rr2_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
// Requester 0 carries sample dumps, requester 1 carries status messages.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        BYTE_WAIT     = 3'd1,
        TX_WAIT_EMPTY = 3'd2,
        LOAD          = 3'd3
    } state_e;

    localparam int REQ_SAMPLE = 0;
    localparam int REQ_STATUS = 1;

    localparam logic [1:0] GRANT_NONE = 2'b00;

endpackage

// File: rtl/rr2_pick.sv
// Two-way one-hot arbiter pick: round-robin on a tie, or fixed priority to
// requester 0 when fixed_prio is set. Purely combinational.
module rr2_pick
    import uart_tx_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] pick
);

    always_comb begin
        pick = GRANT_NONE;
        if (req_valid == 2'b11) begin
            // last_grant names the requester served most recently
            if (fixed_prio || last_grant) begin
                pick[REQ_SAMPLE] = 1'b1;
            end else begin
                pick[REQ_STATUS] = 1'b1;
            end
        end else begin
            pick = req_valid;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two valid/ready byte streams, granting
// a whole frame (up to the byte flagged last) before re-arbitrating.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1000000,
    parameter int TIMEOUT_W  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    output logic [1:0] grant,
    input  logic       uart_txempty,
    output logic       uart_ld_tx_data,
    output logic [7:0] uart_tx_data,
    output logic       timeout_err,
    output logic       busy,
    output logic [2:0] state_debug
);

    localparam bit                   TMO_EN   = (TIMEOUT > 0);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_grant_q, last_grant_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [7:0]           byte_q, byte_d;
    logic                 last_q, last_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [1:0] pick;
    logic       gidx;
    logic       hs;

    rr2_pick u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO != 0),
        .pick       (pick)
    );

    assign gidx = grant_q[REQ_STATUS];
    assign hs   = (state_q == BYTE_WAIT) && req_valid[gidx];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        timer_d       = '0;
        byte_d        = byte_q;
        last_d        = last_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = BYTE_WAIT;
                end
            end
            BYTE_WAIT: begin
                // a handshake on the timeout cycle still wins
                if (hs) begin
                    byte_d  = gidx ? req_data1 : req_data0;
                    last_d  = req_last[gidx];
                    state_d = TX_WAIT_EMPTY;
                end else if (TMO_EN && timer_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    grant_d       = GRANT_NONE;
                    last_grant_d  = gidx;
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TX_WAIT_EMPTY: begin
                if (uart_txempty) state_d = LOAD;
            end
            LOAD: begin
                // UART dropping empty means it has taken the byte
                if (!uart_txempty) begin
                    if (last_q) begin
                        grant_d      = GRANT_NONE;
                        last_grant_d = gidx;
                        state_d      = IDLE;
                    end else begin
                        state_d = BYTE_WAIT;
                    end
                end
            end
            default: begin
                grant_d = GRANT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= GRANT_NONE;
            last_grant_q  <= 1'b1;
            timer_q       <= '0;
            byte_q        <= '0;
            last_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            timer_q       <= timer_d;
            byte_q        <= byte_d;
            last_q        <= last_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ready       = (state_q == BYTE_WAIT) ? grant_q : GRANT_NONE;
    assign grant           = grant_q;
    assign uart_ld_tx_data = (state_q == LOAD);
    assign uart_tx_data    = byte_q;
    assign timeout_err     = timeout_err_q;
    assign busy            = (state_q != IDLE);
    assign state_debug     = state_q;

endmodule
